video_timing_gen: RTL and testbench

//  Programmable raster timing generator for the VDP pixel pipeline; supersedes the fixed 720p VGA timer.

---
 rtl/video_timing_gen_pkg.sv | 26 ++
 rtl/video_timing_gen_if.sv | 13 +
 rtl/video_timing_gen_axis.sv | 58 +++++
 rtl/video_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared types and default 720p timing for the VDP raster timing generator.
package vdp_video_pkg;

    localparam int CORDW_MAX = 16;
    localparam int TOTW      = CORDW_MAX + 2;

    typedef struct packed {
        logic [CORDW_MAX-1:0] act;
        logic [CORDW_MAX-1:0] fp;
        logic [CORDW_MAX-1:0] syn;
        logic [CORDW_MAX-1:0] bp;
    } axis_timing_t;

    typedef enum logic {
        CFG_FREE,
        CFG_HELD
    } cfg_state_t;

    localparam axis_timing_t H_720P = '{act: 16'd1280, fp: 16'd8, syn: 16'd32, bp: 16'd40};
    localparam axis_timing_t V_720P = '{act: 16'd720,  fp: 16'd7, syn: 16'd8,  bp: 16'd6};

    function automatic logic [TOTW-1:0] axis_total(input axis_timing_t t);
        return TOTW'(t.act) + TOTW'(t.fp) + TOTW'(t.syn) + TOTW'(t.bp);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Run-time timing reload handshake between a configuring master and the timing generator.
interface video_timing_gen_if #(
    parameter int CORDW = 11
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [4*CORDW-1:0] cfg_h;
    logic [4*CORDW-1:0] cfg_v;
    logic               cfg_err;

    modport master (output cfg_valid, cfg_h, cfg_v, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_h, cfg_v, output cfg_ready, cfg_err);
endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: position counter with wrap, plus sync/active/last decode of the next position.
module video_axis_counter
    import vdp_video_pkg::*;
#(
    parameter int CORDW = 11,
    parameter bit POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  axis_timing_t     cur,
    input  axis_timing_t     nxt,
    output logic [CORDW-1:0] pos,
    output logic [CORDW-1:0] pos_n,
    output logic             wrap,
    output logic             last_n,
    output logic             sync_n,
    output logic             active_n
);
    localparam int TW = CORDW + 2;

    logic [TW-1:0] cur_total;
    logic [TW-1:0] nxt_total;
    logic [TW-1:0] pos_w;
    logic [TW-1:0] sync_lo;
    logic [TW-1:0] sync_hi;
    logic          sync_raw;

    // Wrap uses the timing of the line/frame in progress; decode uses the timing that applies next.
    always_comb begin
        cur_total = TW'(axis_total(cur));
        nxt_total = TW'(axis_total(nxt));
        wrap      = en && (TW'(pos) == cur_total - 1'b1);
        if (!en) begin
            pos_n = pos;
        end else if (wrap) begin
            pos_n = '0;
        end else begin
            pos_n = pos + 1'b1;
        end
        pos_w    = TW'(pos_n);
        sync_lo  = TW'(nxt.act) + TW'(nxt.fp);
        sync_hi  = sync_lo + TW'(nxt.syn);
        sync_raw = (pos_w >= sync_lo) && (pos_w < sync_hi);
        sync_n   = sync_raw ? POL : ~POL;
        active_n = pos_w < TW'(nxt.act);
        last_n   = pos_w == nxt_total - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else begin
            pos <= pos_n;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: H/V counters, frame-boundary timing reload and line prefetch strobe.
module video_timing_gen
    import vdp_video_pkg::*;
#(
    parameter int CORDW    = 11,
    parameter int H_ACT    = int'(H_720P.act),
    parameter int H_FP     = int'(H_720P.fp),
    parameter int H_SYN    = int'(H_720P.syn),
    parameter int H_BP     = int'(H_720P.bp),
    parameter int V_ACT    = int'(V_720P.act),
    parameter int V_FP     = int'(V_720P.fp),
    parameter int V_SYN    = int'(V_720P.syn),
    parameter int V_BP     = int'(V_720P.bp),
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PREFETCH = 16
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    video_timing_gen_if.slave cfg,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line,
    output logic              frame,
    output logic              line_pre,
    output logic [CORDW-1:0]  pre_sy
);
    localparam int TW = CORDW + 2;
    localparam logic [TW-1:0] LIMIT = TW'(2**CORDW);

    localparam axis_timing_t H_DEF = '{act: CORDW_MAX'(H_ACT), fp: CORDW_MAX'(H_FP),
                                       syn: CORDW_MAX'(H_SYN), bp: CORDW_MAX'(H_BP)};
    localparam axis_timing_t V_DEF = '{act: CORDW_MAX'(V_ACT), fp: CORDW_MAX'(V_FP),
                                       syn: CORDW_MAX'(V_SYN), bp: CORDW_MAX'(V_BP)};

    if (PREFETCH < 1 || PREFETCH > H_FP + H_SYN + H_BP) begin : g_bad_prefetch
        $error("PREFETCH must lie in 1..H_FP+H_SYN+H_BP");
    end
    if (CORDW < 2 || CORDW > CORDW_MAX) begin : g_bad_cordw
        $error("CORDW out of supported range");
    end

    function automatic axis_timing_t unpack_axis(input logic [4*CORDW-1:0] f);
        axis_timing_t t;
        t.act = CORDW_MAX'(f[4*CORDW-1 -: CORDW]);
        t.fp  = CORDW_MAX'(f[3*CORDW-1 -: CORDW]);
        t.syn = CORDW_MAX'(f[2*CORDW-1 -: CORDW]);
        t.bp  = CORDW_MAX'(f[CORDW-1 -: CORDW]);
        return t;
    endfunction

    function automatic logic [TW-1:0] total(input axis_timing_t t);
        return TW'(axis_total(t));
    endfunction

    axis_timing_t     act_h, act_v, shd_h, shd_v, nxt_h, nxt_v, off_h, off_v;
    cfg_state_t       state, state_n;
    logic             offer_bad, accept, load;
    logic             h_wrap, v_wrap;
    logic [CORDW-1:0] sx_n, sy_n;
    logic             h_last_n, v_last_n, h_sync_n, v_sync_n, h_act_n, v_act_n;
    logic [TW-1:0]    ht_n, vt_n, sy_w, pre_line;
    logic             pre_hit;

    always_comb begin
        off_h     = unpack_axis(cfg.cfg_h);
        off_v     = unpack_axis(cfg.cfg_v);
        offer_bad = (off_h.act == '0) || (off_h.syn == '0) ||
                    (off_v.act == '0) || (off_v.syn == '0) ||
                    (total(off_h) > LIMIT) || (total(off_v) > LIMIT);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state <= CFG_FREE;
        end else begin
            state <= state_n;
        end
    end

    // A capture made in the frame-end cycle sees CFG_FREE there, so it waits for the next boundary.
    always_comb begin
        state_n = state;
        case (state)
            CFG_FREE: if (cfg.cfg_valid && !offer_bad) state_n = CFG_HELD;
            CFG_HELD: if (v_wrap) state_n = CFG_FREE;
            default:  state_n = CFG_FREE;
        endcase
    end

    always_comb begin
        cfg.cfg_ready = (state == CFG_FREE);
        accept        = (state == CFG_FREE) && cfg.cfg_valid && !offer_bad;
        load          = (state == CFG_HELD) && v_wrap;
        nxt_h         = load ? shd_h : act_h;
        nxt_v         = load ? shd_v : act_v;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            act_h       <= H_DEF;
            act_v       <= V_DEF;
            shd_h       <= H_DEF;
            shd_v       <= V_DEF;
            cfg.cfg_err <= 1'b0;
        end else begin
            act_h       <= nxt_h;
            act_v       <= nxt_v;
            cfg.cfg_err <= (state == CFG_FREE) && cfg.cfg_valid && offer_bad;
            if (accept) begin
                shd_h <= off_h;
                shd_v <= off_v;
            end
        end
    end

    video_axis_counter #(.CORDW(CORDW), .POL(HS_POL)) u_h_axis (
        .clk      (clk_pix),
        .rst      (rst_pix),
        .en       (1'b1),
        .cur      (act_h),
        .nxt      (nxt_h),
        .pos      (sx),
        .pos_n    (sx_n),
        .wrap     (h_wrap),
        .last_n   (h_last_n),
        .sync_n   (h_sync_n),
        .active_n (h_act_n)
    );

    video_axis_counter #(.CORDW(CORDW), .POL(VS_POL)) u_v_axis (
        .clk      (clk_pix),
        .rst      (rst_pix),
        .en       (h_wrap),
        .cur      (act_v),
        .nxt      (nxt_v),
        .pos      (sy),
        .pos_n    (sy_n),
        .wrap     (v_wrap),
        .last_n   (v_last_n),
        .sync_n   (v_sync_n),
        .active_n (v_act_n)
    );

    // Prefetch names the line that follows the one being scanned, wrapping to line 0 after the last.
    always_comb begin
        ht_n     = total(nxt_h);
        vt_n     = total(nxt_v);
        sy_w     = TW'(sy_n);
        pre_line = (sy_w == vt_n - 1'b1) ? '0 : sy_w + 1'b1;
        pre_hit  = (TW'(sx_n) == ht_n - TW'(PREFETCH)) && (pre_line < TW'(nxt_v.act));
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            de       <= 1'b1;
            line     <= 1'b0;
            frame    <= 1'b0;
            line_pre <= 1'b0;
            pre_sy   <= '0;
        end else begin
            hsync    <= h_sync_n;
            vsync    <= v_sync_n;
            de       <= h_act_n && v_act_n;
            line     <= h_last_n;
            frame    <= h_last_n && v_last_n;
            line_pre <= pre_hit;
            if (pre_hit) begin
                pre_sy <= CORDW'(pre_line);
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: per-cycle comparison against an arithmetic raster model plus directed literal checks.
module tb_video_timing_gen;
    import vdp_video_pkg::*;

    localparam int CW  = 11;
    localparam int PRE = 3;
    localparam int LIM = 2**CW;

    typedef struct {
        int act;
        int fp;
        int syn;
        int bp;
    } tim_t;

    localparam tim_t H_DEF = '{act: 8, fp: 2, syn: 2, bp: 4};
    localparam tim_t V_DEF = '{act: 4, fp: 1, syn: 1, bp: 2};

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] sx, sy, pre_sy;
    logic          hsync, vsync, de, line, frame, line_pre;

    video_timing_gen_if #(.CORDW(CW)) cfg_bus ();

    video_timing_gen #(
        .CORDW(CW), .H_ACT(8), .H_FP(2), .H_SYN(2), .H_BP(4),
        .V_ACT(4), .V_FP(1), .V_SYN(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(PRE)
    ) dut (
        .clk_pix  (clk),
        .rst_pix  (rst),
        .cfg      (cfg_bus.slave),
        .sx       (sx),
        .sy       (sy),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .line     (line),
        .frame    (frame),
        .line_pre (line_pre),
        .pre_sy   (pre_sy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int total(input tim_t t);
        return t.act + t.fp + t.syn + t.bp;
    endfunction

    function automatic tim_t split(input logic [4*CW-1:0] f);
        tim_t t;
        t.act = int'(f[4*CW-1 -: CW]);
        t.fp  = int'(f[3*CW-1 -: CW]);
        t.syn = int'(f[2*CW-1 -: CW]);
        t.bp  = int'(f[CW-1 -: CW]);
        return t;
    endfunction

    function automatic logic [4*CW-1:0] pack(input int a, input int f, input int s, input int b);
        return {CW'(a), CW'(f), CW'(s), CW'(b)};
    endfunction

    // Reference raster: integer position plus frame-boundary reload, evaluated straight from the timing rules.
    bit          mvalid = 1'b0;
    int          mx, my, mpre, ht, vt, nxt_line;
    tim_t        mh, mv, ph, pv, oh, ov;
    bit          mpend, merr, obad, offer, swap;
    bit          e_hs, e_vs, e_de, e_line, e_frame, e_lpre;
    logic [40:0] exp_vec;
    logic [40:0] act_vec;

    always @(posedge clk) begin
        if (rst) begin
            mx = 0; my = 0; mh = H_DEF; mv = V_DEF; ph = H_DEF; pv = V_DEF;
            mpend = 1'b0; merr = 1'b0; mpre = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            oh    = split(cfg_bus.cfg_h);
            ov    = split(cfg_bus.cfg_v);
            obad  = (oh.act == 0) || (oh.syn == 0) || (ov.act == 0) || (ov.syn == 0) ||
                    (total(oh) > LIM) || (total(ov) > LIM);
            offer = !mpend && cfg_bus.cfg_valid;
            merr  = offer && obad;
            swap  = mpend && (mx == total(mh) - 1) && (my == total(mv) - 1);
            if (mx == total(mh) - 1) begin
                mx = 0;
                my = (my == total(mv) - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            if (swap) begin
                mh = ph; mv = pv; mpend = 1'b0;
            end
            if (offer && !obad) begin
                ph = oh; pv = ov; mpend = 1'b1;
            end
        end
        if (mvalid) begin
            ht       = total(mh);
            vt       = total(mv);
            nxt_line = (my == vt - 1) ? 0 : my + 1;
            e_hs     = !((mx >= mh.act + mh.fp) && (mx < mh.act + mh.fp + mh.syn));
            e_vs     = !((my >= mv.act + mv.fp) && (my < mv.act + mv.fp + mv.syn));
            e_de     = (mx < mh.act) && (my < mv.act);
            e_line   = (mx == ht - 1);
            e_frame  = e_line && (my == vt - 1);
            e_lpre   = (mx == ht - PRE) && (nxt_line < mv.act);
            if (e_lpre) mpre = nxt_line;
            exp_vec  = {CW'(mx), CW'(my), e_hs, e_vs, e_de, e_line, e_frame, e_lpre,
                        CW'(mpre), !mpend, merr};
        end
    end

    assign act_vec = {sx, sy, hsync, vsync, de, line, frame, line_pre, pre_sy,
                      cfg_bus.cfg_ready, cfg_bus.cfg_err};

    always @(negedge clk) begin
        if (mvalid) checkOutput("cycle", 64'(act_vec), 64'(exp_vec));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v);
        cfg_bus.cfg_h     = h;
        cfg_bus.cfg_v     = v;
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic nextFrame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame && n < 300);
        if (!frame) checkOutput("frame_timeout", 64'(frame), 64'd1);
    endtask

    task automatic nextLine(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!line && n < 40);
        if (!line) checkOutput("line_timeout", 64'(line), 64'd1);
    endtask

    task automatic waitPos(input int x, input int y);
        for (int i = 0; i < 400 && !(sx == CW'(x) && sy == CW'(y)); i++) tick();
        checkOutput("wait_pos", 64'({sx, sy}), 64'({CW'(x), CW'(y)}));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    int hs_low, hs_ok, vs_low, vs_ok, de_cnt, de_ok, lp, lp_sy_sum, lp_pre_sum, lp_bad;

    initial begin
        rst               = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_h     = pack(8, 2, 2, 4);
        cfg_bus.cfg_v     = pack(4, 1, 1, 2);
        repeat (3) tick();
        checkOutput("reset_sx", 64'(sx), 64'd0);
        checkOutput("reset_sy", 64'(sy), 64'd0);
        checkOutput("reset_de", 64'(de), 64'd1);
        checkOutput("reset_sync", 64'({hsync, vsync}), 64'b11);
        checkOutput("reset_strobes", 64'({line, frame, line_pre, cfg_bus.cfg_err}), 64'd0);
        checkOutput("reset_ready", 64'(cfg_bus.cfg_ready), 64'd1);
        rst = 1'b0;

        nextFrame(n);
        checkOutput("first_frame", 64'(n), 64'd127);
        nextFrame(n);
        checkOutput("frame_period", 64'(n), 64'd128);
        tick();
        checkOutput("frame_wrap", 64'({sx, sy}), 64'd0);

        hs_low = 0; hs_ok = 0; vs_low = 0; vs_ok = 0; de_cnt = 0; de_ok = 0;
        lp = 0; lp_sy_sum = 0; lp_pre_sum = 0; lp_bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (!hsync) hs_low++;
            if (!hsync && (sx == 10 || sx == 11)) hs_ok++;
            if (!vsync) vs_low++;
            if (!vsync && sy == 5) vs_ok++;
            if (de) de_cnt++;
            if (de && sx < 8 && sy < 4) de_ok++;
            if (line_pre) begin
                lp++;
                lp_sy_sum  += int'(sy);
                lp_pre_sum += int'(pre_sy);
                if (sx != 13 || (sy >= 3 && sy <= 6)) lp_bad++;
            end
            tick();
        end
        checkOutput("hsync_low_count", 64'(hs_low), 64'd16);
        checkOutput("hsync_low_at_10_11", 64'(hs_ok), 64'd16);
        checkOutput("vsync_low_count", 64'(vs_low), 64'd16);
        checkOutput("vsync_low_at_5", 64'(vs_ok), 64'd16);
        checkOutput("de_count", 64'(de_cnt), 64'd32);
        checkOutput("de_in_active", 64'(de_ok), 64'd32);
        checkOutput("prefetch_count", 64'(lp), 64'd4);
        checkOutput("prefetch_sy_sum", 64'(lp_sy_sum), 64'd10);
        checkOutput("prefetch_pre_sy_sum", 64'(lp_pre_sum), 64'd6);
        checkOutput("prefetch_misplaced", 64'(lp_bad), 64'd0);

        waitPos(5, 2);
        applyStimulus(pack(4, 1, 1, 2), pack(4, 1, 1, 2));
        checkOutput("cfg_ready_drop", 64'(cfg_bus.cfg_ready), 64'd0);
        nextFrame(n);
        checkOutput("old_timing_end_sx", 64'(sx), 64'd15);
        tick();
        checkOutput("new_frame_ready", 64'({cfg_bus.cfg_ready, sx, sy}), 64'({1'b1, CW'(0), CW'(0)}));
        nextLine(n);
        checkOutput("new_first_line", 64'(n), 64'd7);
        nextLine(n);
        checkOutput("new_line_period", 64'(n), 64'd8);
        nextFrame(n);
        nextFrame(n);
        checkOutput("new_frame_period", 64'(n), 64'd64);

        applyStimulus(pack(4, 1, 1, 2), pack(0, 1, 1, 2));
        checkOutput("err_act_zero", 64'({cfg_bus.cfg_err, cfg_bus.cfg_ready}), 64'b11);
        tick();
        checkOutput("err_single_pulse", 64'(cfg_bus.cfg_err), 64'd0);
        applyStimulus(pack(2047, 2, 1, 0), pack(4, 1, 1, 2));
        checkOutput("err_total_too_big", 64'({cfg_bus.cfg_err, cfg_bus.cfg_ready}), 64'b11);
        nextFrame(n);
        nextFrame(n);
        checkOutput("err_timing_kept", 64'(n), 64'd64);

        applyStimulus(pack(8, 2, 2, 4), pack(4, 1, 1, 2));
        checkOutput("frame_cycle_capture", 64'({cfg_bus.cfg_ready, sx, sy}), 64'({1'b0, CW'(0), CW'(0)}));
        nextLine(n);
        checkOutput("deferred_line_period", 64'(n), 64'd7);
        nextFrame(n);
        checkOutput("deferred_end_sx", 64'(sx), 64'd7);
        tick();
        checkOutput("deferred_ready", 64'(cfg_bus.cfg_ready), 64'd1);
        nextLine(n);
        checkOutput("deferred_applied", 64'(n), 64'd15);

        waitPos(4, 2);
        applyStimulus(pack(4, 1, 1, 2), pack(4, 1, 1, 2));
        checkOutput("pending_before_reset", 64'({cfg_bus.cfg_ready, sx, sy}), 64'({1'b0, CW'(5), CW'(2)}));
        rst = 1'b1;
        tick();
        checkOutput("reset_mid_frame", 64'({cfg_bus.cfg_ready, sx, sy}), 64'({1'b1, CW'(0), CW'(0)}));
        rst = 1'b0;
        nextFrame(n);
        checkOutput("reset_default_frame", 64'(n), 64'd127);
        nextFrame(n);
        checkOutput("pending_discarded", 64'(n), 64'd128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
